// File: rtl/event_encoder.sv
// event_encoder: serializes (x, y, t, p) events into a 7-byte frame over a
// valid/ready byte stream. Define EVENT_ENCODER_CRC_EN to append an XOR
// checksum byte, which makes the frame 8 bytes long.
module event_encoder #(
  parameter bit DROP_NEG = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_t,
  input  logic        in_p,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] evt_count
);

`ifdef EVENT_ENCODER_CRC_EN
  localparam int unsigned FRAME_LEN = 8;
`else
  localparam int unsigned FRAME_LEN = 7;
`endif
  localparam int unsigned IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_nx;
  logic [IDX_W-1:0] idx_q, idx_nx;
  logic [15:0]      hold_x_q, hold_x_nx;
  logic [15:0]      hold_y_q, hold_y_nx;
  logic [15:0]      hold_t_q, hold_t_nx;
  logic             hold_p_q, hold_p_nx;
  logic [15:0]      evt_count_nx;
  logic             byte_xfer;
  logic             last_xfer;
  logic             accept;

  // State, byte index, holding register and event counter
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      hold_x_q  <= '0;
      hold_y_q  <= '0;
      hold_t_q  <= '0;
      hold_p_q  <= 1'b0;
      evt_count <= '0;
    end else begin
      state_q   <= state_nx;
      idx_q     <= idx_nx;
      hold_x_q  <= hold_x_nx;
      hold_y_q  <= hold_y_nx;
      hold_t_q  <= hold_t_nx;
      hold_p_q  <= hold_p_nx;
      evt_count <= evt_count_nx;
    end
  end

  // Next-state, handshakes and frame sequencing
  always_comb begin : fsm_comb
    state_nx     = state_q;
    idx_nx       = idx_q;
    hold_x_nx    = hold_x_q;
    hold_y_nx    = hold_y_q;
    hold_t_nx    = hold_t_q;
    hold_p_nx    = hold_p_q;
    evt_count_nx = evt_count;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    byte_xfer    = 1'b0;
    last_xfer    = 1'b0;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        byte_xfer = out_ready;
        last_xfer = out_ready && (idx_q == LAST_IDX);
        // Accepting alongside the last byte lets frames run back-to-back
        in_ready  = last_xfer;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    accept = in_valid && in_ready;

    if (byte_xfer) begin
      idx_nx = idx_q + IDX_W'(1);
    end

    if (last_xfer) begin
      evt_count_nx = evt_count + 16'd1;
      state_nx     = IDLE;
      idx_nx       = '0;
    end

    if (accept) begin
      hold_x_nx = in_x;
      hold_y_nx = in_y;
      hold_t_nx = in_t;
      hold_p_nx = in_p;
      // Negative events are latched but never framed when DROP_NEG is set
      if (!(DROP_NEG && !in_p)) begin
        state_nx = SEND;
        idx_nx   = '0;
      end
    end
  end

`ifdef EVENT_ENCODER_CRC_EN
  logic [7:0] crc;

  // Checksum over the seven header/payload bytes
  always_comb begin : crc_comb
    crc = {7'b1010101, hold_p_q} ^ hold_x_q[15:8] ^ hold_x_q[7:0]
        ^ hold_y_q[15:8] ^ hold_y_q[7:0] ^ hold_t_q[15:8] ^ hold_t_q[7:0];
  end
`endif

  // Byte select from the holding register; zero outside a frame
  always_comb begin : byte_mux
    out_data = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0:    out_data = {7'b1010101, hold_p_q};
        3'd1:    out_data = hold_x_q[15:8];
        3'd2:    out_data = hold_x_q[7:0];
        3'd3:    out_data = hold_y_q[15:8];
        3'd4:    out_data = hold_y_q[7:0];
        3'd5:    out_data = hold_t_q[15:8];
        3'd6:    out_data = hold_t_q[7:0];
`ifdef EVENT_ENCODER_CRC_EN
        3'd7:    out_data = crc;
`endif
        default: out_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_event_encoder.sv
// tb_event_encoder: table-driven frame checks plus hand-written sequences for
// back-to-back frames, mid-frame reset, counter wrap and negative-event drop.
module tb_event_encoder;

`ifdef EVENT_ENCODER_CRC_EN
  localparam int FL = 8;
`else
  localparam int FL = 7;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_x = '0, in_y = '0, in_t = '0;
  logic        in_p = 1'b0, in_valid = 1'b0, out_ready = 1'b0;

  logic        in_ready, out_valid, busy;
  logic [7:0]  out_data;
  logic [15:0] evt_count;
  logic        d_in_ready, d_out_valid, d_busy;
  logic [7:0]  d_out_data;
  logic [15:0] d_evt_count;

  always #5 clk = ~clk;

  event_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_t(in_t),
    .in_p(in_p), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .evt_count(evt_count)
  );

  event_encoder #(.DROP_NEG(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_t(in_t),
    .in_p(in_p), .in_valid(in_valid), .in_ready(d_in_ready),
    .out_data(d_out_data), .out_valid(d_out_valid), .out_ready(out_ready),
    .busy(d_busy), .evt_count(d_evt_count)
  );

  // Selects which instance the shared helper tasks observe
  logic        sel_d = 1'b0;
  logic        cur_valid, cur_in_ready, cur_busy;
  logic [7:0]  cur_data;
  logic [15:0] cur_cnt;
  assign cur_valid    = sel_d ? d_out_valid : out_valid;
  assign cur_in_ready = sel_d ? d_in_ready  : in_ready;
  assign cur_busy     = sel_d ? d_busy      : busy;
  assign cur_data     = sel_d ? d_out_data  : out_data;
  assign cur_cnt      = sel_d ? d_evt_count : evt_count;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] t;
    logic        p;
    logic [7:0]  rdy;    // out_ready pattern, bit n used on cycle n mod 8
    logic [63:0] bytes;  // expected frame, byte 0 in the top bits, checksum last
  } vec_t;

  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [63:0] b, input int i);
    return b[63-8*i -: 8];
  endfunction

  // Receive one frame starting at a negedge where byte 0 is presented
  task automatic recv(input logic [63:0] b, input logic [7:0] rdy);
    int k = 0;
    int cyc = 0;
    while (k < FL && cyc < 200) begin
      out_ready = rdy[cyc % 8];
      #1;
      chk("out_valid", 32'(cur_valid), 32'd1);
      chk("busy", 32'(cur_busy), 32'd1);
      chk($sformatf("byte%0d", k), 32'(cur_data), 32'(exp_byte(b, k)));
      chk($sformatf("in_ready_at%0d", k), 32'(cur_in_ready), 32'((k == FL - 1) && out_ready));
      if (out_ready) k++;
      cyc++;
      @(negedge clk);
    end
    if (k < FL) chk("recv_timeout", 32'(k), 32'(FL));
    out_ready = 1'b0;
  endtask

  // Present one event to an idle encoder and check its whole frame
  task automatic send_frame(input vec_t v, input logic [15:0] cnt);
    @(negedge clk);
    in_x = v.x; in_y = v.y; in_t = v.t; in_p = v.p;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("in_ready_idle", 32'(cur_in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_x = ~v.x; in_y = ~v.y; in_t = ~v.t; in_p = ~v.p;
    chk("first_byte_latency", 32'(cur_valid), 32'd1);
    recv(v.bytes, v.rdy);
    chk("evt_count", 32'(cur_cnt), 32'(cnt));
    chk("idle_after_frame", 32'(cur_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{x:16'h1234, y:16'h5678, t:16'h9ABC, p:1'b1, rdy:8'hFF, bytes:64'hAB12_3456_789A_BC85};
    vecs[1] = '{x:16'h0000, y:16'h0000, t:16'h0000, p:1'b0, rdy:8'h99, bytes:64'hAA00_0000_0000_00AA};
    vecs[2] = '{x:16'hFFFF, y:16'hFFFF, t:16'hFFFF, p:1'b1, rdy:8'h55, bytes:64'hABFF_FFFF_FFFF_FFAB};
    vecs[3] = '{x:16'h00FF, y:16'hFF00, t:16'h0F1E, p:1'b0, rdy:8'hAA, bytes:64'hAA00_FFFF_000F_1EBB};
    vecs[4] = '{x:16'hA5C3, y:16'h0102, t:16'h8000, p:1'b1, rdy:8'h6D, bytes:64'hABA5_C301_0280_004E};

    // Reset values
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_evt_count", 32'(evt_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table of single frames with various stall patterns
    exp_cnt = 16'd0;
    for (int i = 0; i < 5; i++) begin
      exp_cnt = exp_cnt + 16'd1;
      send_frame(vecs[i], exp_cnt);
    end

    // Back-to-back frames with no idle cycle between them
    @(negedge clk);
    in_x = vecs[0].x; in_y = vecs[0].y; in_t = vecs[0].t; in_p = vecs[0].p;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 2 * FL; k++) begin
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk($sformatf("b2b_byte%0d", k), 32'(out_data),
          32'((k < FL) ? exp_byte(vecs[0].bytes, k) : exp_byte(vecs[4].bytes, k - FL)));
      if (k == FL - 1) begin
        in_x = vecs[4].x; in_y = vecs[4].y; in_t = vecs[4].t; in_p = vecs[4].p;
        in_valid = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd2;
    chk("b2b_idle", 32'(out_valid), 32'd0);
    chk("b2b_evt_count", 32'(evt_count), 32'(exp_cnt));

    // Reset after byte idx3 aborts the frame
    @(negedge clk);
    in_x = vecs[0].x; in_y = vecs[0].y; in_t = vecs[0].t; in_p = vecs[0].p;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort_byte%0d", k), 32'(out_data), 32'(exp_byte(vecs[0].bytes, k)));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'h00);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_evt_count", 32'(evt_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_tail", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    send_frame(vecs[1], 16'd1);

    // Counter wraps from 0xFFFF to 0x0000
    force dut.evt_count = 16'hFFFF;
    @(negedge clk);
    release dut.evt_count;
    @(negedge clk);
    chk("wrap_preload", 32'(evt_count), 32'h0000_FFFF);
    send_frame(vecs[2], 16'h0000);

    // DROP_NEG: negative event swallowed, positive event framed
    do_reset();
    sel_d = 1'b1;
    @(negedge clk);
    in_x = vecs[3].x; in_y = vecs[3].y; in_t = vecs[3].t; in_p = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("drop_no_valid", 32'(d_out_valid), 32'd0);
    chk("drop_not_busy", 32'(d_busy), 32'd0);
    chk("drop_in_ready", 32'(d_in_ready), 32'd1);
    @(negedge clk);
    chk("drop_still_idle", 32'(d_out_valid), 32'd0);
    send_frame(vecs[0], 16'd1);
    sel_d = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
